// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the hazard/forwarding logic:
// opcodes, interlock status encoding and the shadow-slot record.
package rv_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I_LD  = 7'b0000011;
   localparam logic [6:0] OP_I_IMM = 7'b0010011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_e;

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
   } slot_t;

endpackage

// File: rtl/hazard_ctrl_src_decode.sv
// Source-operand decode: extracts rs1/rs2 and whether the opcode reads them.
// Shared with the forwarding unit so both agree on what counts as a source.
module src_decode
   import rv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        rs1_use,
   output logic        rs2_use
);

   logic [6:0] opcode;
   logic       unused_fields;

   assign opcode = instr[6:0];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];

   // funct and rd/imm fields never affect which registers are read
   assign unused_fields = ^{instr[31:25], instr[14:12], instr[11:7]};

   always_comb begin
      rs1_use = 1'b0;
      rs2_use = 1'b0;
      unique case (opcode)
         OP_R, OP_S, OP_B: begin
            rs1_use = 1'b1;
            rs2_use = 1'b1;
         end
         OP_I_LD, OP_I_IMM, OP_JALR: begin
            rs1_use = 1'b1;
         end
         default: begin
            rs1_use = 1'b0;
            rs2_use = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock and flush controller for the non-forwarding 5-stage core: tracks
// EX/MEM/WB destinations, stalls ID on a RAW match, flushes on redirect.
module hazard_ctrl
   import rv_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [31:0]      i_id_instr,
   input  logic             i_id_vld,
   input  logic             i_id_rd_wren,
   input  logic             i_br_taken,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_flush,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [4:0] rs1, rs2, rd_id;
   logic       rs1_use, rs2_use;
   logic       hazard;
   state_e     state_d, state_q;
   slot_t      ex_nxt;

   // shadow slots: _p0 = EX, _p1 = MEM, _p2 = WB
   logic       vld_p0, vld_p1, vld_p2;
   logic [4:0] rd_p0, rd_p1, rd_p2;

   function automatic logic slot_hit(input logic [4:0] src, input logic vld,
                                     input logic [4:0] rd);
      return vld && (rd != 5'd0) && (rd == src);
   endfunction

   function automatic logic src_blocked(input logic [4:0] src, input logic use_f,
                                        input logic v0, input logic [4:0] r0,
                                        input logic v1, input logic [4:0] r1,
                                        input logic v2, input logic [4:0] r2);
      return use_f && (src != 5'd0) &&
             (slot_hit(src, v0, r0) || slot_hit(src, v1, r1) || slot_hit(src, v2, r2));
   endfunction

   src_decode u_src_decode (
      .instr   (i_id_instr),
      .rs1     (rs1),
      .rs2     (rs2),
      .rs1_use (rs1_use),
      .rs2_use (rs2_use)
   );

   assign rd_id  = i_id_instr[11:7];
   assign hazard = i_id_vld &&
                   (src_blocked(rs1, rs1_use, vld_p0, rd_p0, vld_p1, rd_p1, vld_p2, rd_p2) ||
                    src_blocked(rs2, rs2_use, vld_p0, rd_p0, vld_p1, rd_p1, vld_p2, rd_p2));

   // Redirect outranks the interlock: a stalled ID instruction on the wrong
   // path must be discarded, not waited for.
   always_comb begin
      state_d       = RUN;
      o_pc_en       = 1'b1;
      o_if_id_en    = 1'b1;
      o_if_id_flush = 1'b0;
      o_id_ex_flush = 1'b0;
      if (i_br_taken) begin
         state_d       = FLUSH;
         o_if_id_flush = 1'b1;
         o_id_ex_flush = 1'b1;
      end else if (hazard) begin
         state_d       = STALL;
         o_pc_en       = 1'b0;
         o_if_id_en    = 1'b0;
         o_id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      ex_nxt.vld = (state_d == RUN) && i_id_vld && i_id_rd_wren && (rd_id != 5'd0);
      ex_nxt.rd  = rd_id;
   end

   // ---- stage boundary: ID -> EX -> MEM -> WB shadow shift ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= ex_nxt.vld;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge i_clk) begin
      rd_p0 <= ex_nxt.rd;
      rd_p1 <= rd_p0;
      rd_p2 <= rd_p1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= RUN;
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == STALL) o_stall_cnt <= o_stall_cnt + CNT_ONE;
         if (state_d == FLUSH) o_flush_cnt <= o_flush_cnt + CNT_ONE;
      end
   end

   assign o_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: register-busy reference model plus
// directed dependency scenarios and randomized instruction streams.
module tb_hazard_ctrl;

   localparam int CNT_W = 32;
   localparam logic [6:0] M_R = 7'b0110011, M_LD = 7'b0000011, M_IMM = 7'b0010011,
                          M_JALR = 7'b1100111, M_S = 7'b0100011, M_B = 7'b1100011,
                          M_LUI = 7'b0110111, M_AUIPC = 7'b0010111, M_JAL = 7'b1101111,
                          M_BAD = 7'b1111111;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      id_instr;
   logic             id_vld, id_rd_wren, br_taken;
   logic             pc_en, if_id_en, if_id_flush, id_ex_flush;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_id_instr    (id_instr),
      .i_id_vld      (id_vld),
      .i_id_rd_wren  (id_rd_wren),
      .i_br_taken    (br_taken),
      .o_pc_en       (pc_en),
      .o_if_id_en    (if_id_en),
      .o_if_id_flush (if_id_flush),
      .o_id_ex_flush (id_ex_flush),
      .o_state       (state),
      .o_stall_cnt   (stall_cnt),
      .o_flush_cnt   (flush_cnt)
   );

   typedef struct {
      logic [3:0]  ctl;   // {pc_en, if_id_en, if_id_flush, id_ex_flush}
      logic [1:0]  st;
      logic [31:0] sc;
      logic [31:0] fc;
      int          cyc;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: a register is busy through the cycle its writer
   // leaves WB; busy[r] is the last cycle in which r may not be read.
   int busy[32];
   int cyc = 0;
   int mstate = 0;
   int mstall = 0;
   int mflush = 0;

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b0, rd, op};
   endfunction

   function automatic void reads(input logic [6:0] op, output logic u1, output logic u2);
      u1 = 1'b0;
      u2 = 1'b0;
      if (op == M_R || op == M_S || op == M_B) begin
         u1 = 1'b1;
         u2 = 1'b1;
      end else if (op == M_LD || op == M_IMM || op == M_JALR) begin
         u1 = 1'b1;
      end
   endfunction

   task automatic drive(input logic [31:0] ins, input logic v, input logic w,
                        input logic b, output logic pc);
      exp_t       e;
      logic       u1, u2, hz;
      logic [4:0] s1, s2, rd;
      int         res;
      id_instr   = ins;
      id_vld     = v;
      id_rd_wren = w;
      br_taken   = b;
      if (!rst_n) begin
         foreach (busy[i]) busy[i] = -1;
         mstate = 0;
         mstall = 0;
         mflush = 0;
      end
      s1 = ins[19:15];
      s2 = ins[24:20];
      rd = ins[11:7];
      reads(ins[6:0], u1, u2);
      hz = v && ((u1 && s1 != 0 && busy[s1] >= cyc) || (u2 && s2 != 0 && busy[s2] >= cyc));
      res = b ? 2 : (hz ? 1 : 0);
      e.ctl = (res == 2) ? 4'b1111 : ((res == 1) ? 4'b0001 : 4'b1100);
      e.st  = 2'(mstate);
      e.sc  = 32'(mstall);
      e.fc  = 32'(mflush);
      e.cyc = cyc;
      sbq.push_back(e);
      if (rst_n) begin
         mstate = res;
         if (res == 1) mstall++;
         if (res == 2) mflush++;
         if (res == 0 && v && w && rd != 0) busy[rd] = cyc + 3;
      end
      cyc++;
      #1 pc = pc_en;
      @(posedge clk);
      #1;
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, req);
      end
   endtask

   // Hold the instruction in ID until the DUT lets it issue; count stalls.
   task automatic issue(input logic [31:0] ins, input logic w, output int stalls);
      logic pc;
      int   k;
      stalls = 0;
      k = 0;
      do begin
         drive(ins, 1'b1, w, 1'b0, pc);
         if (!pc) stalls++;
         k++;
      end while (!pc && k < 8);
   endtask

   task automatic nops(input int n);
      logic pc;
      for (int i = 0; i < n; i++) drive(enc(M_IMM, 5'd0, 5'd0, 5'd0), 1'b1, 1'b1, 1'b0, pc);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [3:0] act;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = {pc_en, if_id_en, if_id_flush, id_ex_flush};
            checks++;
            if (act !== e.ctl) begin
               errors++;
               $display("FAIL ctl cyc=%0d got=%b want=%b", e.cyc, act, e.ctl);
            end
            checks++;
            if (state !== e.st) begin
               errors++;
               $display("FAIL state cyc=%0d got=%0d want=%0d", e.cyc, state, e.st);
            end
            checks++;
            if (stall_cnt !== e.sc) begin
               errors++;
               $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.cyc, stall_cnt, e.sc);
            end
            checks++;
            if (flush_cnt !== e.fc) begin
               errors++;
               $display("FAIL flush_cnt cyc=%0d got=%0d want=%0d", e.cyc, flush_cnt, e.fc);
            end
         end
      end
   end

   initial begin : stim
      logic       pc;
      int         n;
      logic [6:0] ops[10];
      ops = '{M_R, M_LD, M_IMM, M_JALR, M_S, M_B, M_LUI, M_AUIPC, M_JAL, M_BAD};
      foreach (busy[i]) busy[i] = -1;
      rst_n = 1'b0;
      id_instr = '0;
      id_vld = 1'b0;
      id_rd_wren = 1'b0;
      br_taken = 1'b0;
      @(posedge clk);
      #1;
      drive(enc(M_IMM, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, pc);
      rst_n = 1'b1;

      // back-to-back RAW: addi x5,x0,1 ; add x6,x5,x5
      issue(enc(M_IMM, 5'd5, 5'd0, 5'd0), 1'b1, n);
      issue(enc(M_R, 5'd6, 5'd5, 5'd5), 1'b1, n);
      check_int("stall_d1", n, 3);
      check_int("stall_cnt_d1", int'(stall_cnt), 3);
      nops(4);

      // distance 2, 3, 4 via nops between producer and sub x7,x5,x1
      for (int d = 1; d <= 3; d++) begin
         issue(enc(M_IMM, 5'd5, 5'd0, 5'd0), 1'b1, n);
         nops(d);
         issue(enc(M_R, 5'd7, 5'd5, 5'd1), 1'b1, n);
         check_int($sformatf("stall_gap%0d", d), n, 3 - d);
         nops(4);
      end

      // x0 producer and source-less LUI
      issue(enc(M_IMM, 5'd0, 5'd0, 5'd0), 1'b1, n);
      issue(enc(M_R, 5'd1, 5'd0, 5'd0), 1'b1, n);
      check_int("stall_x0", n, 0);
      issue(enc(M_LUI, 5'd3, 5'd0, 5'd0), 1'b1, n);
      issue(enc(M_LUI, 5'd4, 5'd3, 5'd3), 1'b1, n);
      check_int("stall_lui", n, 0);
      nops(4);

      // taken branch while ID holds a dependent add
      issue(enc(M_IMM, 5'd5, 5'd0, 5'd0), 1'b1, n);
      drive(enc(M_R, 5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b1, pc);
      check_int("br_pc_en", int'(pc), 1);
      check_int("br_state", int'(state), 2);
      nops(4);

      // lw x5 ; sw x5,0(x2)  and  jal x1 ; add x2,x1,x0
      issue(enc(M_LD, 5'd5, 5'd2, 5'd0), 1'b1, n);
      issue(enc(M_S, 5'd0, 5'd2, 5'd5), 1'b0, n);
      check_int("stall_sw_rs2", n, 3);
      nops(4);
      issue(enc(M_JAL, 5'd1, 5'd0, 5'd0), 1'b1, n);
      issue(enc(M_R, 5'd2, 5'd1, 5'd0), 1'b1, n);
      check_int("stall_jal", n, 3);
      nops(4);

      // reset in the second stall cycle drops the pending producer
      issue(enc(M_IMM, 5'd5, 5'd0, 5'd0), 1'b1, n);
      drive(enc(M_R, 5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b0, pc);
      check_int("rst_pre_stall", int'(pc), 0);
      rst_n = 1'b0;
      drive(enc(M_R, 5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b0, pc);
      check_int("rst_cnt", int'(stall_cnt), 0);
      rst_n = 1'b1;
      issue(enc(M_R, 5'd6, 5'd5, 5'd5), 1'b1, n);
      check_int("stall_after_rst", n, 0);

      for (int i = 0; i < 400; i++) begin
         drive(enc(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
               1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) == 0), pc);
      end

      @(negedge clk);
      #1;
      check_int("sb_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline interlock and flush controller for the non-forwarding five-stage RV32I core (IF, ID, EX, MEM, WB). It holds a shadow copy of the destination-register information for EX, MEM and WB and compares it against the sources of the instruction in ID. It stalls IF/ID and injects bubbles into EX until the producer has retired, and flushes wrong-path instructions when EX resolves a taken branch or jump. It also keeps stall and flush performance counters.

## Interface
- CNT_W, 32, width of the performance counters.
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_id_instr  in  32  instruction word currently in ID.
- i_id_vld  in  1  ID holds a real instruction, not a bubble.
- i_id_rd_wren  in  1  rd_wren from the control unit for the ID instruction.
- i_br_taken  in  1  br_sel of the instruction in EX. High means PC redirect this cycle.
- o_pc_en  out  1  PC register enable.
- o_if_id_en  out  1  IF/ID pipeline register enable.
- o_if_id_flush  out  1  load a bubble into IF/ID.
- o_id_ex_flush  out  1  load a bubble into ID/EX.
- o_state  out  2  registered status of the previous cycle: RUN=0, STALL=1, FLUSH=2.
- o_stall_cnt  out  CNT_W  number of cycles spent stalled.
- o_flush_cnt  out  CNT_W  number of redirects taken.

## Operation
- Sources are decoded from the opcode:
  - rs1 = instr[19:15]. It is used by every opcode except LUI, AUIPC and JAL.
  - rs2 = instr[24:20]. It is used by R, S and B opcodes only.
  - rd = instr[11:7].
  - Unknown opcodes use no sources.
  - A source equal to x0 never causes a hazard.
- Each shadow slot (EX, MEM, WB) holds {vld, rd}. A slot is a producer when vld=1 and rd≠0.
- The register file is not write-through. A producer in any of EX, MEM or WB blocks a matching source in ID.
- hazard = i_id_vld & any used source equals the rd of any valid slot.
- Output priority, evaluated combinationally in the same cycle:
  - If i_br_taken: FLUSH. o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1, o_if_id_en=1. Flush wins over a hazard, because the stalled ID instruction is on the wrong path.
  - Else if hazard: STALL. o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_if_id_flush=0.
  - Else: RUN. o_pc_en=1, o_if_id_en=1, both flushes 0.
- Shadow shift on each clock edge:
  - EX ← bubble if STALL or FLUSH; otherwise {i_id_vld & i_id_rd_wren & (rd≠0), rd}.
  - MEM ← EX.
  - WB ← MEM.
- Counters:
  - o_stall_cnt increments in every STALL cycle.
  - o_flush_cnt increments in every FLUSH cycle.
  - Both wrap modulo 2^CNT_W.
- o_state registers the priority result of the current cycle.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert externally guaranteed):
  - All shadow slots invalid.
  - o_state=RUN.
  - Both counters 0.
  - With i_br_taken=0, the combinational outputs then read o_pc_en=1, o_if_id_en=1, flushes 0.
- Reset mid-stall drops all pending producers. The first cycle after reset is RUN.
- Stall latency is 0 cycles: the hazard is detected and o_pc_en drops in the same cycle the consumer is in ID.
- Dependent-instruction stall length:
  - Back-to-back (producer in EX): 3 stall cycles. The consumer issues on the cycle after the producer leaves WB.
  - Distance 2: 2 stall cycles.
  - Distance 3: 1 stall cycle.
  - Distance ≥4: 0 stall cycles.
- A flush costs exactly 1 cycle in this block. The two younger instructions become bubbles and do not enter the shadow slots.
- The branch or JAL/JALR itself is already in the EX slot. JAL/JALR with rd≠0 remains a producer.
- Branch taken in the same cycle as a hazard: one FLUSH cycle, stall count unchanged, o_flush_cnt +1.

## Structure
- Package rv_pkg:
  - opcode localparams: R, I_LD, I_IMM, JALR, S, B, LUI, AUIPC, JAL.
  - state enum: RUN, STALL, FLUSH.
  - slot struct {logic vld; logic [4:0] rd}.
- One natural sub-module, src_decode: combinational, derives rs1/rs2 and their use flags from an instruction word. It is reused by the future forwarding unit.
- Top level contains the three shadow slots, comparators, priority logic, state register and counters.

## Test plan
- addi x5,x0,1 followed immediately by add x6,x5,x5 → o_pc_en=0 for exactly 3 cycles, add issues on the 4th cycle, o_stall_cnt=3.
- addi x5 / nop / sub x7,x5,x1 → 2 stall cycles; with 2 nops between producer and consumer → 1 stall cycle; with 3 nops → 0.
- addi x0,x0,5 followed by add x1,x0,x0 → no stall (x0 rule). lui x3 followed by lui x4 → no stall (LUI has no sources).
- beq taken while ID holds a dependent add → in the same cycle o_if_id_flush=1, o_id_ex_flush=1, o_pc_en=1, o_state=FLUSH next cycle, o_flush_cnt=1, o_stall_cnt unchanged.
- sw x5,0(x2) one cycle after lw x5 → stall detected on rs2, 3 cycles. jal x1 followed by add x2,x1,x0 with no redirect → 3 stall cycles.
- Assert i_rst_n=0 during the 2nd stall cycle → slots clear, counters 0; after release with the same ID instruction → RUN, no stall.
